// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the receiver and the transmitter:
//   - DATA_BITS     : number of payload bits per frame
//   - rx_state_t    : receiver FSM state encoding
//   - clks_per_bit(): baud divider, system clocks per serial bit
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Integer division: any fractional remainder becomes a small, fixed rate
    // error that the mid-bit sampling absorbs.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   d     in  asynchronous input
//   q     out synchronized output (two clocks of latency)
// Parameter RESET_VAL sets what both flops hold in reset, so that the
// downstream logic sees an inactive level until the line is really sampled.
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver, 8N1 by default (8E1 when UART_RX_PARITY_EN is defined).
// Samples the asynchronous RxD line at mid-bit and presents each good byte
// with a one-cycle valid strobe.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-high reset
//   RxD        in  serial line, idle high, asynchronous to clk
//   data       out last correctly received byte (holds until the next one)
//   valid      out one-cycle pulse when data updates
//   frame_err  out one-cycle pulse when the stop bit samples 0
//   parity_err out one-cycle pulse on even-parity mismatch (0 without macro)
//   busy       out high from start-bit detection until return to IDLE
// Configuration macro: UART_RX_PARITY_EN
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

`ifdef UART_RX_PARITY_EN
    logic                 par_flag;
`endif

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (RxD),
        .q     (rxs)
    );

    // Receiver FSM. cnt counts down to the next mid-bit sample point; the
    // half-bit load in IDLE moves every later sample to the centre of a bit.
    // The status strobes default low each cycle so they are exactly one wide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_flag   <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        cnt   <= HALF_LOAD;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end

                // A start bit that is high again at its centre was a glitch.
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt     <= FULL_LOAD;
                        bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        par_flag <= 1'b0;
`endif
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift_reg[bit_idx] <= rxs;
                        cnt                <= FULL_LOAD;
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                // Even parity: the parity bit equals the XOR of the data bits.
                PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        par_flag <= (rxs != (^shift_reg));
                        cnt      <= FULL_LOAD;
                        state    <= STOP;
                    end
                end
`endif

                // A low stop bit may be a break; WAIT_IDLE keeps it from
                // being re-detected as a stream of new start bits.
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_flag) begin
                            parity_err <= 1'b1;
                        end else begin
                            data  <= shift_reg;
                            valid <= 1'b1;
                        end
`else
                        data  <= shift_reg;
                        valid <= 1'b1;
`endif
                    end else begin
                        frame_err <= 1'b1;
                        state     <= WAIT_IDLE;
                    end
                end

                WAIT_IDLE: begin
                    if (rxs) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule
